eeprom_slave: RTL and testbench

- Synthesizable responder for the two-wire serial EEPROM protocol. It is the other end of the existing EEPROM read/write master on SCL/SDA.
- Holds a 2^ADDR_W x 8 byte array and decodes start, stop, control, address and data bytes. Drives ACK and read data onto SDA as an open-drain output.
- Used as the on-board EEPROM model and as the loopback target for master verification.
- Oversamples SCL/SDA with the system clock. CLK must be at least 8x the SCL frequency.

---
 rtl/eeprom_slave.sv | 212 +++++++++++++++++++++
 tb/tb_eeprom_slave.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_slave.sv
// eeprom_slave: two-wire serial EEPROM responder with a 2^ADDR_W x 8
// byte array and an open-drain SDA output.
// Ports: CLK/RESET (async active-low) system; SCL/SDA serial bus;
// BUSY transaction active; WR_STB/WR_ADDR/WR_DATA commit strobe;
// DBG_ADDR/DBG_DATA combinational backdoor read.
module eeprom_slave #(
  parameter int         ADDR_W = 11,
  parameter logic [3:0] DEV_ID = 4'b1010
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              BUSY,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic [7:0]        DBG_DATA
);

  typedef enum logic [3:0] {
    IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;

  localparam int         HI_W    = ADDR_W - 8;
  localparam logic [2:0] HI_MASK = 3'((1 << HI_W) - 1);

  logic [7:0] mem [2**ADDR_W];

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic rise, fall, start, stop;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [6:0]        sh, sh_n;
  logic [7:0]        rbuf, rbuf_n;
  logic [ADDR_W-1:0] ptr, ptr_n, ptr_hi;
  logic              oe, oe_n;
  logic              busy_n, rw, rw_n, stb_n, we;
  logic [ADDR_W-1:0] wa_n;
  logic [7:0]        wd_n, din;
  logic [3:0]        rsel;

  assign SDA      = oe ? 1'b0 : 1'bz;
  assign DBG_DATA = mem[DBG_ADDR];

  // Events are judged on the synchronized sample vs. the delayed one;
  // a simultaneous SCL change disqualifies start/stop.
  assign rise  = scl_s2 & ~scl_d;
  assign fall  = ~scl_s2 & scl_d;
  assign start = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop  = scl_s2 & scl_d & ~sda_d & sda_s2;

  assign din    = {sh, sda_s2};
  assign rsel   = 4'd7 - cnt;
  // Control bits [3:1] carry the high address bits, masked to width.
  assign ptr_hi = ADDR_W'({din[3:1] & HI_MASK, ptr[7:0]});

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {SCL, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {SDA, sda_s1, sda_s2};
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      rbuf    <= '0;
      ptr     <= '0;
      oe      <= 1'b0;
      BUSY    <= 1'b0;
      rw      <= 1'b0;
      WR_STB  <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      rbuf    <= rbuf_n;
      ptr     <= ptr_n;
      oe      <= oe_n;
      BUSY    <= busy_n;
      rw      <= rw_n;
      WR_STB  <= stb_n;
      WR_ADDR <= wa_n;
      WR_DATA <= wd_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) mem[ptr] <= din;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    rbuf_n  = rbuf;
    ptr_n   = ptr;
    oe_n    = oe;
    busy_n  = BUSY;
    rw_n    = rw;
    stb_n   = 1'b0;
    wa_n    = WR_ADDR;
    wd_n    = WR_DATA;
    we      = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      cnt_n   = '0;
    end else if (start) begin
      state_n = CTRL;
      oe_n    = 1'b0;
      busy_n  = 1'b1;
      cnt_n   = '0;
    end else begin
      unique case (state)
        CTRL: if (rise) begin
          sh_n  = din[6:0];
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n = '0;
            if (din[7:4] == DEV_ID) begin
              state_n = CTRL_ACK;
              rw_n    = din[0];
              if (!din[0]) ptr_n = ptr_hi;
            end else begin
              state_n = WAIT;
            end
          end
        end
        // cnt==0: 8th fall, start ACK; cnt==1: 9th fall, end ACK.
        CTRL_ACK, ADDR_ACK, WDATA_ACK: if (fall) begin
          if (cnt == 4'd0) begin
            oe_n  = 1'b1;
            cnt_n = 4'd1;
          end else begin
            oe_n  = 1'b0;
            cnt_n = '0;
            if (state == CTRL_ACK && rw) begin
              rbuf_n  = mem[ptr];
              oe_n    = ~mem[ptr][7];
              cnt_n   = 4'd1;
              state_n = RDATA;
            end else if (state == CTRL_ACK) begin
              state_n = ADDR;
            end else begin
              state_n = WDATA;
              if (state == WDATA_ACK) ptr_n = ptr + ADDR_W'(1);
            end
          end
        end
        ADDR: if (rise) begin
          sh_n  = din[6:0];
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            ptr_n[7:0] = din;
            cnt_n      = '0;
            state_n    = ADDR_ACK;
          end
        end
        WDATA: if (rise) begin
          sh_n  = din[6:0];
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            we      = 1'b1;
            stb_n   = 1'b1;
            wa_n    = ptr;
            wd_n    = din;
            cnt_n   = '0;
            state_n = WDATA_ACK;
          end
        end
        // cnt counts bits already presented; bit 7 went out on entry.
        RDATA: if (fall) begin
          if (cnt == 4'd8) begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = RDATA_ACK;
          end else begin
            oe_n  = ~rbuf[rsel[2:0]];
            cnt_n = cnt + 4'd1;
          end
        end
        RDATA_ACK: begin
          if (rise) begin
            ptr_n = ptr + ADDR_W'(1);
            if (sda_s2) state_n = WAIT;
            else cnt_n = 4'd1;
          end else if (fall && cnt == 4'd1) begin
            rbuf_n  = mem[ptr];
            oe_n    = ~mem[ptr][7];
            state_n = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_slave.sv
// tb_eeprom_slave: directed bus-master bench for eeprom_slave.
// Drives SCL/SDA with an open-drain master and checks ACKs, data, strobes.
module tb_eeprom_slave;
  localparam int AW = 11;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          SCL = 1'b1;
  logic          m_sda = 1'b1;
  wire           SDA;
  logic          BUSY, WR_STB;
  logic [AW-1:0] WR_ADDR;
  logic [AW-1:0] DBG_ADDR = '0;
  logic [7:0]    WR_DATA, DBG_DATA;

  int            total = 0;
  int            bad = 0;
  int            stb_cnt = 0;
  logic [AW-1:0] last_a = '0;
  logic [7:0]    last_d = '0;

  assign SDA = m_sda ? 1'bz : 1'b0;
  pullup (SDA);

  always #5 CLK = ~CLK;

  eeprom_slave #(.ADDR_W(AW), .DEV_ID(4'b1010)) dut (
    .CLK(CLK), .RESET(RESET), .SCL(SCL), .SDA(SDA),
    .BUSY(BUSY), .WR_STB(WR_STB), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
  );

  always @(negedge CLK) begin
    if (WR_STB === 1'b1) begin
      stb_cnt++;
      last_a = WR_ADDR;
      last_d = WR_DATA;
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic wq();
    repeat (10) @(posedge CLK);
    #1;
  endtask

  task automatic m_start();
    m_sda = 1'b1; wq();
    SCL = 1'b1;   wq();
    m_sda = 1'b0; wq();
    SCL = 1'b0;   wq();
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wq();
    SCL = 1'b1;   wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic m_bit(input logic b, output logic s);
    m_sda = b;  wq();
    SCL = 1'b1; wq();
    s = SDA;    wq();
    SCL = 1'b0; wq();
  endtask

  task automatic m_wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_rbyte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(nack, s);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (BUSY !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", BUSY);
    end
    total++;
    if (WR_STB !== 1'b0) begin
      bad++; $display("FAIL reset_stb got=%b want=0", WR_STB);
    end
    total++;
    if (WR_ADDR !== 11'h000 || WR_DATA !== 8'h00) begin
      bad++;
      $display("FAIL reset_wr got=%h/%h want=000/00", WR_ADDR, WR_DATA);
    end
    total++;
    if (SDA !== 1'b1) begin
      bad++; $display("FAIL reset_sda got=%b want=1", SDA);
    end
    RESET = 1'b1;
    wq();
  endtask

  task automatic test_byte_write();
    logic a1, a2, a3;
    int n0;
    n0 = stb_cnt;
    m_start();
    m_wbyte(8'hA0, a1);
    m_wbyte(8'h34, a2);
    m_wbyte(8'h5A, a3);
    total++;
    if ({a1, a2, a3} !== 3'b000) begin
      bad++; $display("FAIL bw_acks got=%b want=000", {a1, a2, a3});
    end
    total++;
    if (stb_cnt - n0 != 1 || last_a !== 11'h034 || last_d !== 8'h5A) begin
      bad++;
      $display("FAIL bw_stb got=%0d@%h=%h want=1@034=5a",
               stb_cnt - n0, last_a, last_d);
    end
    total++;
    if (BUSY !== 1'b1) begin
      bad++; $display("FAIL bw_busy got=%b want=1", BUSY);
    end
    m_stop();
    wq();
    total++;
    if (BUSY !== 1'b0) begin
      bad++; $display("FAIL bw_idle got=%b want=0", BUSY);
    end
    DBG_ADDR = 11'h034;
    #1;
    total++;
    if (DBG_DATA !== 8'h5A) begin
      bad++; $display("FAIL bw_mem got=%h want=5a", DBG_DATA);
    end
  endtask

  task automatic test_random_read();
    logic a1, a2, a3, a4;
    logic [7:0] d;
    int n0;
    m_start();
    m_wbyte(8'hAA, a1);
    m_wbyte(8'h34, a2);
    m_wbyte(8'hC3, a3);
    m_stop();
    n0 = stb_cnt;
    m_start();
    m_wbyte(8'hAA, a1);
    m_wbyte(8'h34, a2);
    m_start();
    m_wbyte(8'hAB, a4);
    m_rbyte(1'b1, d);
    m_stop();
    total++;
    if ({a1, a2, a4} !== 3'b000) begin
      bad++; $display("FAIL rr_acks got=%b want=000", {a1, a2, a4});
    end
    total++;
    if (d !== 8'hC3) begin
      bad++; $display("FAIL rr_data got=%h want=c3", d);
    end
    total++;
    if (stb_cnt != n0) begin
      bad++; $display("FAIL rr_nostb got=%0d want=0", stb_cnt - n0);
    end
  endtask

  task automatic test_seq_wrap();
    logic a1, a2, a3, a4;
    int n0;
    n0 = stb_cnt;
    m_start();
    m_wbyte(8'hAE, a1);
    m_wbyte(8'hFF, a2);
    m_wbyte(8'h11, a3);
    m_wbyte(8'h22, a4);
    m_stop();
    total++;
    if ({a1, a2, a3, a4} !== 4'b0000) begin
      bad++; $display("FAIL wrap_acks got=%b want=0000", {a1, a2, a3, a4});
    end
    total++;
    if (stb_cnt - n0 != 2 || last_a !== 11'h000 || last_d !== 8'h22) begin
      bad++;
      $display("FAIL wrap_stb got=%0d@%h=%h want=2@000=22",
               stb_cnt - n0, last_a, last_d);
    end
    DBG_ADDR = 11'h7FF;
    #1;
    total++;
    if (DBG_DATA !== 8'h11) begin
      bad++; $display("FAIL wrap_7ff got=%h want=11", DBG_DATA);
    end
    DBG_ADDR = 11'h000;
    #1;
    total++;
    if (DBG_DATA !== 8'h22) begin
      bad++; $display("FAIL wrap_000 got=%h want=22", DBG_DATA);
    end
  endtask

  task automatic test_wrong_dev();
    logic a1, a2, a3;
    int n0;
    n0 = stb_cnt;
    m_start();
    m_wbyte(8'hB0, a1);
    m_wbyte(8'h34, a2);
    m_wbyte(8'h99, a3);
    total++;
    if ({a1, a2, a3} !== 3'b111) begin
      bad++; $display("FAIL wd_nack got=%b want=111", {a1, a2, a3});
    end
    total++;
    if (BUSY !== 1'b1) begin
      bad++; $display("FAIL wd_busy got=%b want=1", BUSY);
    end
    m_stop();
    wq();
    total++;
    if (BUSY !== 1'b0 || stb_cnt != n0) begin
      bad++;
      $display("FAIL wd_end got=busy%b stb%0d want=busy0 stb0",
               BUSY, stb_cnt - n0);
    end
  endtask

  task automatic test_abort();
    logic a1, a2, a3, s;
    logic [7:0] d;
    int n0;
    m_start();
    m_wbyte(8'hA0, a1);
    m_wbyte(8'h20, a2);
    m_wbyte(8'h77, a3);
    m_stop();
    n0 = stb_cnt;
    m_start();
    m_wbyte(8'hA0, a1);
    m_wbyte(8'h20, a2);
    m_bit(1'b1, s);
    m_bit(1'b0, s);
    m_bit(1'b1, s);
    m_bit(1'b0, s);
    m_stop();
    wq();
    DBG_ADDR = 11'h020;
    #1;
    total++;
    if (stb_cnt != n0 || DBG_DATA !== 8'h77) begin
      bad++;
      $display("FAIL ab_partial got=stb%0d mem%h want=stb0 mem77",
               stb_cnt - n0, DBG_DATA);
    end
    total++;
    if (BUSY !== 1'b0) begin
      bad++; $display("FAIL ab_stop_busy got=%b want=0", BUSY);
    end
    m_start();
    m_wbyte(8'hA0, a1);
    m_bit(1'b0, s);
    m_bit(1'b0, s);
    m_bit(1'b1, s);
    m_sda = 1'b1;
    RESET = 1'b0;
    #1;
    total++;
    if (BUSY !== 1'b0 || SDA !== 1'b1) begin
      bad++; $display("FAIL ab_rst got=busy%b sda%b want=busy0 sda1", BUSY, SDA);
    end
    total++;
    if (WR_ADDR !== 11'h000 || WR_DATA !== 8'h00) begin
      bad++;
      $display("FAIL ab_rst_wr got=%h/%h want=000/00", WR_ADDR, WR_DATA);
    end
    SCL = 1'b1;
    wq();
    RESET = 1'b1;
    wq();
    m_start();
    m_wbyte(8'hA1, a1);
    m_rbyte(1'b1, d);
    m_stop();
    total++;
    if (a1 !== 1'b0 || d !== 8'h22) begin
      bad++; $display("FAIL ab_ptr0 got=ack%b %h want=ack0 22", a1, d);
    end
  endtask

  task automatic test_seq_read();
    logic a1, a2, a3, a4, a5;
    logic [7:0] d1, d2, d3;
    m_start();
    m_wbyte(8'hA0, a1);
    m_wbyte(8'h10, a2);
    m_wbyte(8'h01, a3);
    m_wbyte(8'h02, a4);
    m_wbyte(8'h03, a5);
    m_stop();
    total++;
    if ({a1, a2, a3, a4, a5} !== 5'b00000) begin
      bad++; $display("FAIL sr_pre got=%b want=00000", {a1, a2, a3, a4, a5});
    end
    m_start();
    m_wbyte(8'hA0, a1);
    m_wbyte(8'h10, a2);
    m_start();
    m_wbyte(8'hA1, a3);
    m_rbyte(1'b0, d1);
    m_rbyte(1'b1, d2);
    m_stop();
    total++;
    if (d1 !== 8'h01 || d2 !== 8'h02) begin
      bad++; $display("FAIL sr_data got=%h,%h want=01,02", d1, d2);
    end
    m_start();
    m_wbyte(8'hA1, a4);
    m_rbyte(1'b1, d3);
    m_stop();
    total++;
    if ({a1, a2, a3, a4} !== 4'b0000 || d3 !== 8'h03) begin
      bad++;
      $display("FAIL sr_ptr got=acks%b %h want=acks0000 03",
               {a1, a2, a3, a4}, d3);
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_random_read();
    test_seq_wrap();
    test_wrong_dev();
    test_abort();
    test_seq_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
